// File: rtl/seg_dp_argmin_if.sv
// Emin stream in, D-table read port, and the per-row argmin result.
interface seg_dp_argmin_if #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160
);
    localparam int IW = $clog2(I);

    logic [IW-1:0]        i_in;
    logic                 start_in;
    logic [IW-1:0]        j_in;
    logic [BIT_WIDTH-1:0] emin_in;
    logic                 emin_valid_in;
    logic [IW-1:0]        D_req;
    logic [BIT_WIDTH-1:0] D_resp;
    logic [IW-1:0]        i_out;
    logic [IW-1:0]        best_j_out;
    logic [BIT_WIDTH-1:0] best_cost_out;
    logic                 result_valid;
    logic                 busy_out;

    modport slave (
        input  i_in, start_in, j_in, emin_in,
        input  emin_valid_in, D_resp,
        output D_req, i_out, best_j_out,
        output best_cost_out, result_valid, busy_out
    );

    modport master (
        output i_in, start_in, j_in, emin_in,
        output emin_valid_in, D_resp,
        input  D_req, i_out, best_j_out,
        input  best_cost_out, result_valid, busy_out
    );
endinterface

// File: rtl/seg_dp_argmin.sv
// DP argmin over j of Emin(j,i) + D(j-1); emits D(i) and backpointer j*.
// Optional macro SEG_PENALTY_EN adds SEG_PENALTY to every candidate cost.
module seg_dp_argmin #(
    parameter int BIT_WIDTH   = 32,
    parameter int I           = 160
`ifdef SEG_PENALTY_EN
    ,
    parameter int SEG_PENALTY = 0
`endif
) (
    input logic clk_in,
    input logic rst_in,
    seg_dp_argmin_if.slave bus
);
    localparam int IW = $clog2(I);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} st_t;

    typedef struct packed {
        logic                 v;
        logic                 last;
        logic [IW-1:0]        j;
        logic [BIT_WIDTH-1:0] e;
    } ent_t;

    st_t                  st, st_nxt;
    ent_t                 s1, s2, s3;
    logic                 fin;
    logic [IW-1:0]        i_reg;
    logic [BIT_WIDTH-1:0] best;
    logic [IW-1:0]        best_j;

    logic                 push, last_in, better;
    logic [BIT_WIDTH-1:0] dterm, cost, c0;
    logic [BIT_WIDTH:0]   sum;
`ifdef SEG_PENALTY_EN
    logic [BIT_WIDTH:0]   sum_p;
`endif

    always_comb begin
        push    = (st == RUN) && bus.emin_valid_in &&
                  (bus.j_in <= i_reg);
        last_in = (bus.j_in == i_reg);
        st_nxt  = st;
        unique case (st)
            IDLE:    if (bus.start_in) st_nxt = RUN;
            RUN:     if (push && last_in) st_nxt = DRAIN;
            DRAIN:   if (fin) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
        bus.busy_out = (st != IDLE);
    end

    // Cost is formed at BIT_WIDTH+1 bits and clamped to all-ones.
    always_comb begin
        dterm = (s3.j == '0) ? '0 : bus.D_resp;
        sum   = {1'b0, s3.e} + {1'b0, dterm};
        c0    = sum[BIT_WIDTH] ? '1 : sum[BIT_WIDTH-1:0];
`ifdef SEG_PENALTY_EN
        sum_p = {1'b0, c0} + (BIT_WIDTH+1)'(SEG_PENALTY);
        cost  = sum_p[BIT_WIDTH] ? '1 : sum_p[BIT_WIDTH-1:0];
`else
        cost  = c0;
`endif
        better = s3.v && (cost < best);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            st                <= IDLE;
            s1                <= '0;
            s2                <= '0;
            s3                <= '0;
            fin               <= 1'b0;
            i_reg             <= '0;
            best              <= '1;
            best_j            <= '0;
            bus.D_req         <= '0;
            bus.i_out         <= '0;
            bus.best_j_out    <= '0;
            bus.best_cost_out <= '0;
            bus.result_valid  <= 1'b0;
        end else begin
            st      <= st_nxt;
            s1.v    <= push;
            s1.last <= last_in;
            s1.j    <= bus.j_in;
            s1.e    <= bus.emin_in;
            s2      <= s1;
            s3      <= s2;
            fin     <= s3.v && s3.last;
            if (push) begin
                bus.D_req <= (bus.j_in == '0) ? '0 :
                             bus.j_in - IW'(1);
            end
            if (st == IDLE && bus.start_in) begin
                i_reg  <= bus.i_in;
                best   <= '1;
                best_j <= '0;
            end else if (better) begin
                best   <= cost;
                best_j <= s3.j;
            end
            bus.result_valid <= fin;
            if (fin) begin
                bus.i_out         <= i_reg;
                bus.best_j_out    <= best_j;
                bus.best_cost_out <= best;
            end
        end
    end
endmodule

// File: tb/tb_seg_dp_argmin.sv
// Directed bench for seg_dp_argmin with a 2-cycle D-table model.
module tb_seg_dp_argmin;
`ifdef SEG_PENALTY_EN
    localparam logic [31:0] PEN = 32'd100;
`else
    localparam logic [31:0] PEN = 32'd0;
`endif

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    seg_dp_argmin_if #(.BIT_WIDTH(32), .I(160)) bus();

`ifdef SEG_PENALTY_EN
    seg_dp_argmin #(.SEG_PENALTY(100)) dut (
        .clk_in(clk_in), .rst_in(rst_n), .bus(bus)
    );
`else
    seg_dp_argmin dut (
        .clk_in(clk_in), .rst_in(rst_n), .bus(bus)
    );
`endif

    logic [31:0] dmem [160];
    logic [31:0] r1;
    always @(posedge clk_in) begin
        r1         <= dmem[bus.D_req];
        bus.D_resp <= r1;
    end

    bit mon_en = 0;
    bit dreq_nz = 0;
    always @(negedge clk_in)
        if (mon_en && bus.D_req != 8'd0) dreq_nz = 1;

    int checks = 0;
    int failures = 0;
    logic [31:0] em_q [8];
    logic [7:0]  j_q  [8];
    int n_q;
    int lat;
    bit got;

    task automatic run_row(input logic [7:0] i);
        int cnt;
        bus.i_in = i;
        bus.start_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        bus.start_in = 1'b0;
        for (int k = 0; k < n_q; k++) begin
            bus.j_in = j_q[k];
            bus.emin_in = em_q[k];
            bus.emin_valid_in = 1'b1;
            @(posedge clk_in);
            if (k != n_q - 1) @(negedge clk_in);
        end
        cnt = 0;
        got = 0;
        while (cnt < 20 && !got) begin
            @(negedge clk_in);
            bus.emin_valid_in = 1'b0;
            if (bus.result_valid) got = 1;
            else begin
                @(posedge clk_in);
                cnt++;
            end
        end
        lat = cnt;
    endtask

    task automatic test_reset();
        bus.i_in = '0;
        bus.start_in = 1'b0;
        bus.j_in = '0;
        bus.emin_in = '0;
        bus.emin_valid_in = 1'b0;
        for (int k = 0; k < 160; k++) dmem[k] = '0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy_out !== 1'b0 ||
            bus.best_cost_out !== 32'd0 || bus.best_j_out !== 8'd0 ||
            bus.i_out !== 8'd0 || bus.D_req !== 8'd0) begin
            failures++;
            $display("FAIL reset_state rv=%b busy=%b cost=%h j=%0d i=%0d dreq=%0d req=all zero",
                     bus.result_valid, bus.busy_out, bus.best_cost_out,
                     bus.best_j_out, bus.i_out, bus.D_req);
        end
        rst_n = 1'b1;
        bus.emin_valid_in = 1'b1;
        bus.j_in = 8'd0;
        bus.emin_in = 32'd1;
        repeat (6) @(negedge clk_in);
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore rv=%b busy=%b req=0 0",
                     bus.result_valid, bus.busy_out);
        end
        bus.emin_valid_in = 1'b0;
    endtask

    task automatic test_basic();
        dmem[0] = 32'd10; dmem[1] = 32'd12; dmem[2] = 32'd40;
        em_q[0] = 32'd50; em_q[1] = 32'd20;
        em_q[2] = 32'd30; em_q[3] = 32'd5;
        for (int k = 0; k < 4; k++) j_q[k] = 8'(k);
        n_q = 4;
        run_row(8'd3);
        checks++;
        if (!got || lat != 4) begin
            failures++;
            $display("FAIL basic_latency got=%0d lat=%0d req=1 4", got, lat);
        end
        checks++;
        if (bus.best_cost_out !== 32'd30 + PEN || bus.best_j_out !== 8'd1 ||
            bus.i_out !== 8'd3) begin
            failures++;
            $display("FAIL basic_result cost=%0d j=%0d i=%0d req=%0d 1 3",
                     bus.best_cost_out, bus.best_j_out, bus.i_out, 32'd30 + PEN);
        end
        checks++;
        if (bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy busy=%b req=0", bus.busy_out);
        end
        @(negedge clk_in);
        checks++;
        if (bus.result_valid !== 1'b0 || bus.best_cost_out !== 32'd30 + PEN) begin
            failures++;
            $display("FAIL basic_pulse rv=%b cost=%0d req=0 hold",
                     bus.result_valid, bus.best_cost_out);
        end
    endtask

    task automatic test_tie_drop();
        dmem[0] = 32'd3; dmem[1] = 32'd4; dmem[2] = 32'd0;
        em_q[0] = 32'd7; j_q[0] = 8'd0;
        em_q[1] = 32'd0; j_q[1] = 8'd3;
        em_q[2] = 32'd4; j_q[2] = 8'd1;
        em_q[3] = 32'd5; j_q[3] = 8'd2;
        n_q = 4;
        run_row(8'd2);
        checks++;
        if (!got || lat != 4) begin
            failures++;
            $display("FAIL tie_latency got=%0d lat=%0d req=1 4", got, lat);
        end
        checks++;
        if (bus.best_cost_out !== 32'd7 + PEN || bus.best_j_out !== 8'd0 ||
            bus.i_out !== 8'd2) begin
            failures++;
            $display("FAIL tie_result cost=%0d j=%0d i=%0d req=%0d 0 2",
                     bus.best_cost_out, bus.best_j_out, bus.i_out, 32'd7 + PEN);
        end
    endtask

    task automatic test_back_to_back();
        em_q[0] = 32'd9; j_q[0] = 8'd0;
        em_q[1] = 32'd1; j_q[1] = 8'd1;
        n_q = 2;
        run_row(8'd1);
        checks++;
        if (!got || lat != 4 || bus.best_cost_out !== 32'd4 + PEN ||
            bus.best_j_out !== 8'd1 || bus.i_out !== 8'd1) begin
            failures++;
            $display("FAIL b2b_result got=%0d lat=%0d cost=%0d j=%0d i=%0d req=1 4 %0d 1 1",
                     got, lat, bus.best_cost_out, bus.best_j_out, bus.i_out,
                     32'd4 + PEN);
        end
        @(negedge clk_in);
        checks++;
        if (bus.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pulse rv=%b req=0", bus.result_valid);
        end
    endtask

    task automatic test_saturation();
        dmem[0] = 32'h20; dmem[1] = 32'h10;
        em_q[0] = 32'h200;      j_q[0] = 8'd0;
        em_q[1] = 32'hFFFFFFF0; j_q[1] = 8'd1;
        em_q[2] = 32'hF0;       j_q[2] = 8'd2;
        n_q = 3;
        run_row(8'd2);
        checks++;
        if (!got || bus.best_cost_out !== 32'h100 + PEN ||
            bus.best_j_out !== 8'd2) begin
            failures++;
            $display("FAIL sat_win got=%0d cost=%h j=%0d req=%h 2",
                     got, bus.best_cost_out, bus.best_j_out, 32'h100 + PEN);
        end
        @(negedge clk_in);
        em_q[0] = 32'hFFFFFFFF; j_q[0] = 8'd0;
        em_q[1] = 32'hFFFFFFF0; j_q[1] = 8'd1;
        n_q = 2;
        run_row(8'd1);
        checks++;
        if (!got || bus.best_cost_out !== 32'hFFFFFFFF ||
            bus.best_j_out !== 8'd0) begin
            failures++;
            $display("FAIL sat_clamp got=%0d cost=%h j=%0d req=ffffffff 0",
                     got, bus.best_cost_out, bus.best_j_out);
        end
        @(negedge clk_in);
    endtask

    task automatic test_row0();
        dreq_nz = 0;
        mon_en = 1;
        em_q[0] = 32'd42; j_q[0] = 8'd0;
        n_q = 1;
        run_row(8'd0);
        mon_en = 0;
        checks++;
        if (!got || lat != 4 || bus.best_cost_out !== 32'd42 + PEN ||
            bus.best_j_out !== 8'd0 || bus.i_out !== 8'd0) begin
            failures++;
            $display("FAIL row0_result got=%0d lat=%0d cost=%0d j=%0d i=%0d req=1 4 %0d 0 0",
                     got, lat, bus.best_cost_out, bus.best_j_out, bus.i_out,
                     32'd42 + PEN);
        end
        checks++;
        if (dreq_nz) begin
            failures++;
            $display("FAIL row0_dreq nonzero=%0d req=0", dreq_nz);
        end
        @(negedge clk_in);
    endtask

    task automatic test_mid_reset();
        bit seen;
        bus.i_in = 8'd5;
        bus.start_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        bus.start_in = 1'b0;
        bus.j_in = 8'd0; bus.emin_in = 32'd100; bus.emin_valid_in = 1'b1;
        @(negedge clk_in);
        bus.j_in = 8'd1;
        @(posedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy_out !== 1'b0 ||
            bus.best_cost_out !== 32'd0 || bus.best_j_out !== 8'd0 ||
            bus.i_out !== 8'd0 || bus.D_req !== 8'd0) begin
            failures++;
            $display("FAIL midreset_zero rv=%b busy=%b cost=%h j=%0d i=%0d dreq=%0d req=all zero",
                     bus.result_valid, bus.busy_out, bus.best_cost_out,
                     bus.best_j_out, bus.i_out, bus.D_req);
        end
        @(negedge clk_in);
        bus.emin_valid_in = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (bus.result_valid || bus.busy_out) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midreset_quiet activity=%0d req=0", seen);
        end
        dmem[0] = 32'd2;
        em_q[0] = 32'd9; j_q[0] = 8'd0;
        em_q[1] = 32'd3; j_q[1] = 8'd1;
        n_q = 2;
        run_row(8'd1);
        checks++;
        if (!got || lat != 4 || bus.best_cost_out !== 32'd5 + PEN ||
            bus.best_j_out !== 8'd1 || bus.i_out !== 8'd1) begin
            failures++;
            $display("FAIL midreset_next got=%0d lat=%0d cost=%0d j=%0d i=%0d req=1 4 %0d 1 1",
                     got, lat, bus.best_cost_out, bus.best_j_out, bus.i_out,
                     32'd5 + PEN);
        end
        @(negedge clk_in);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_tie_drop();
        test_back_to_back();
        test_saturation();
        test_row0();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_dp_argmin.md
Name: seg_dp_argmin

Overview:
- Consumes the Emin(j, i) stream produced by the segment-error stage, one value per j = 0..i.
- For each candidate j it forms cost(j) = Emin(j, i) + D(j-1), where D is the previous best-cost table held in BRAM. For j = 0 the D term is 0.
- Tracks the running minimum and its argmin, then emits D(i) and the backpointer j* for row i.
- Result feeds the D-table write port and the backtrace buffer.

Parameters:
- BIT_WIDTH, 32, width of Emin, D values and costs (all costs non-negative, unsigned).
- I, 160, number of points; index width is $clog2(I).
- SEG_PENALTY, 0, per-segment constant added to every cost; used only with SEG_PENALTY_EN.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- i_in  input  $clog2(I)  row index; sampled on start_in.
- start_in  input  1  begin row i_in; honoured only in IDLE.
- j_in  input  $clog2(I)  segment start index of the incoming Emin.
- emin_in  input  BIT_WIDTH  Emin(j_in, i).
- emin_valid_in  input  1  emin_in / j_in valid this cycle.
- D_req  output  $clog2(I)  D-table read address.
- D_resp  input  BIT_WIDTH  D-table read data, valid exactly 2 cycles after D_req.
- i_out  output  $clog2(I)  row index of the result.
- best_j_out  output  $clog2(I)  argmin j*.
- best_cost_out  output  BIT_WIDTH  D(i) = min cost.
- result_valid  output  1  one-cycle pulse; also the D-table write enable.
- busy_out  output  1  high from start acceptance until the result pulse.

Behaviour:
- Reset (rst_in low, asynchronous):
  - state = IDLE; D_req, i_out, best_j_out, best_cost_out = 0; result_valid = 0; busy_out = 0.
  - All valid-pipeline bits cleared. Reset mid-row abandons the row with no result pulse.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On start_in: latch i_reg = i_in, best = all-ones, best_j = 0, busy_out = 1, go to RUN.
  - emin_valid_in in IDLE is ignored.
- RUN:
  - Every cycle with emin_valid_in, push {j, emin, last = (j_in == i_reg)} into a 3-deep valid pipeline.
  - Register D_req = j_in - 1, or 0 when j_in == 0.
  - Back-to-back inputs are accepted every cycle; there is no backpressure.
  - When a last entry is pushed, go to DRAIN. Further emin_valid_in is ignored until IDLE.
  - start_in in RUN or DRAIN is ignored.
- Pipeline timing (input sampled at edge t):
  - D_req is driven from t+1.
  - D_resp for that request is sampled at edge t+3.
  - Compare happens at edge t+3, in the same cycle.
- Cost arithmetic:
  - cost = emin + (j == 0 ? 0 : D_resp), computed at BIT_WIDTH+1 bits.
  - Saturate to 2^BIT_WIDTH - 1 on overflow.
- Update rule:
  - If cost < best (strict), then best = cost and best_j = j.
  - On ties the earlier (smaller) j is kept.
- Result: when the last entry is compared at edge t+3:
  - At edge t+4: best_cost_out / best_j_out reflect the final min including that entry; i_out = i_reg; result_valid = 1 for one cycle; busy_out = 0; state = IDLE.
  - Latency from the final Emin sample to result_valid is 4 cycles.
- Output registers hold their values until the next result.
- A new start_in may be accepted in the cycle result_valid is high.
- Row i = 0: a single entry j = 0 gives best_cost = Emin(0, 0) and best_j = 0.
- j values arriving greater than i_reg are dropped (not pushed).

Optional Feature:
- Macro: SEG_PENALTY_EN.
- Defined: every cost has SEG_PENALTY added before the min, using the same saturation. best_cost_out includes the penalty.
- Undefined: penalty logic is absent; cost = emin + D(j-1) exactly.

Test Plan:
- Basic row: i=3, Emin(j,3) = {50, 20, 30, 5}, D = {10, 12, 40}:
  - Costs are 50, 30, 42, 45.
  - Expect best_cost = 30, best_j = 1, i_out = 3, one result_valid pulse 4 cycles after the j=3 sample.
- Tie: i=2, costs {7, 7, 9} → best_j = 0, best_cost = 7.
- Saturation: Emin = 0xFFFFFFF0, D(j-1) = 0x20 → cost 0xFFFFFFFF; another j with cost 0x100 wins with best_j equal to that j.
- Row i=0, Emin(0,0) = 42 → best_cost = 42, best_j = 0; D_req is never driven non-zero.
- Async reset asserted mid-row after j=1 of i=5:
  - Outputs zero immediately, no result_valid.
  - A new start with i=1 then completes correctly.
- SEG_PENALTY_EN with SEG_PENALTY = 100, repeat the basic row:
  - Costs are 150, 130, 142, 145.
  - Expect best_cost = 130, best_j = 1.
